// File: rtl/mux_pipe_pkg.sv
// Shared types and default widths for the mux_pipe responder.
package mux_pipe_pkg;

    localparam int DATA_W         = 8;
    localparam int SEL_W          = 3;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] in;
        logic [SEL_W-1:0]  sel;
    } s1_t;

endpackage

// File: rtl/mux_pipe_resp_if.sv
// Request/response bundle between the mux driver (master) and the responder (slave).
interface mux_pipe_resp_if;
    import mux_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic              out_ready;
    logic              out;
    logic              flush;
    logic              busy;

    modport master (
        output in_valid, in, sel, out_ready, flush,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, in, sel, out_ready, flush,
        output in_ready, out_valid, out, busy
    );

endinterface

// File: rtl/mux_pipe_fifo.sv
// 1-bit-wide synchronous result FIFO with clear; DEPTH must be a power of two.
module mux_pipe_fifo #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic             din,
    input  logic             pop,
    output logic             dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 1'b0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage has no reset; count/empty gate every read, so contents never leak.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mux_pipe_resp.sv
// 8:1 mux responder: 2-stage registered select, result FIFO, flush FSM.
// Optional MUX_PIPE_STATS_EN adds per-select accept counters (stat_sel/stat_cnt).
module mux_pipe_resp
    import mux_pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    mux_pipe_resp_if.slave   bus
`ifdef MUX_PIPE_STATS_EN
    ,
    input  logic [SEL_W-1:0] stat_sel,
    output logic [15:0]      stat_cnt
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FILL_W = CNT_W + 1;
    localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(FIFO_DEPTH);

    state_e             state;
    state_e             state_nxt;
    s1_t                s1;
    logic               s2_v;
    logic               s2_bit;
    logic               ready_q;
    logic               busy_q;
    logic               accept;
    logic               push;
    logic               pop;
    logic               s1_v_nxt;
    logic               s2_v_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [FILL_W-1:0]  fill_nxt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_head;

    // flush wins over both handshakes in the same cycle
    assign accept = bus.in_valid && ready_q && !bus.flush;
    assign pop    = !fifo_empty && bus.out_ready && !bus.flush;
    assign push   = s2_v && (!fifo_full || pop);

    // NOTE: every always_comb output gets a default up front so no latch is inferred.
    always_comb begin
        state_nxt = state;
        s1_v_nxt  = 1'b0;
        s2_v_nxt  = 1'b0;
        count_nxt = '0;
        if (bus.flush) begin
            state_nxt = FLUSH;
        end else begin
            s1_v_nxt  = accept;
            s2_v_nxt  = s1.v;
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
            case (state)
                IDLE:    state_nxt = accept ? RUN : IDLE;
                RUN:     state_nxt = (s1_v_nxt || s2_v_nxt || count_nxt != '0) ? RUN : IDLE;
                FLUSH:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        fill_nxt = FILL_W'(count_nxt) + FILL_W'(s1_v_nxt) + FILL_W'(s2_v_nxt);
    end

    // Ready and busy are registered from next-cycle occupancy, so a pop never opens a slot combinationally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            s1      <= '0;
            s2_v    <= 1'b0;
            s2_bit  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            s1.v    <= s1_v_nxt;
            s2_v    <= s2_v_nxt;
            ready_q <= (state_nxt != FLUSH) && (fill_nxt < DEPTH_F);
            busy_q  <= (state_nxt == FLUSH) || (fill_nxt != '0);
            if (accept) begin
                s1.in  <= bus.in;
                s1.sel <= bus.sel;
            end
            if (s1.v) s2_bit <= s1.in[s1.sel];
        end
    end

    mux_pipe_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .clear  (bus.flush),
        .push   (push),
        .din    (s2_bit),
        .pop    (pop),
        .dout   (fifo_head),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out       = fifo_head;
    assign bus.busy      = busy_q;

`ifdef MUX_PIPE_STATS_EN
    logic [15:0] stat_q [DATA_W];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DATA_W; i++) stat_q[i] <= '0;
        end else if (bus.flush || state == FLUSH) begin
            for (int i = 0; i < DATA_W; i++) stat_q[i] <= '0;
        end else if (accept && stat_q[bus.sel] != 16'hFFFF) begin
            stat_q[bus.sel] <= stat_q[bus.sel] + 16'd1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule
